multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore/Mealy FSM sequencing a multi-cycle MIPS datapath over one shared instruction/data memory port.
//  Issues per-state strobes: fetch, decode, execute, memory, write-back.
//  Stalls on memory wait states; traps illegal opcodes and memory timeouts into a sticky ERROR state.
//  Sits beside the datapath and replaces the single-cycle decoder.
// PARAMETERS
//  MEM_WAIT_MAX  15  max consecutive cycles with mem_ready=0 in a memory state before entering ERROR (1..255)
// PORTS
//  clk        in   1  rising-edge clock
//  reset      in   1  asynchronous, active-low reset
//  opcode     in   6  instr[31:26] from instruction register
//  funct      in   6  instr[5:0] from instruction register
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory completes access this cycle
//  memread    out  1  memory read strobe
//  memwrite   out  1  memory write strobe
//  iord       out  1  0 = address from PC, 1 = address from ALUOut
//  irwrite    out  1  load instruction register
//  pcwrite    out  1  load PC
//  pcsrc      out  2  00 ALU (PC+4), 01 branch target, 10 jump {pc[31:28],tgt,00}, 11 rs (jr)
//  regwrite   out  1  register file write enable
//  regdst     out  2  00 rt, 01 rd, 10 $31
//  memtoreg   out  2  00 ALUOut, 01 memory data, 10 PC+4
//  alusrca    out  1  0 PC, 1 rs
//  alusrcb    out  2  00 rt, 01 const 4, 10 extended immediate, 11 signimm<<2
//  immsel     out  2  00 sign-extend, 01 zero-extend, 10 imm<<16
//  alucontrol out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
//  state      out  4  current state (debug)
//  err        out  1  sticky; 1 in ERROR
//  err_cause  out  2  00 none, 01 illegal opcode/funct, 10 memory timeout
// BEHAVIOUR
//  - reset low (async): state=IDLE(0), wait counter=0, err_cause=00. All outputs 0 in IDLE.
//  - IDLE -> FETCH unconditionally on the first edge after reset release.
//  - States: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9,
//    IEXEC 10, IWB 11, JUMP 12, JR 13, ERROR 15. Unlisted outputs are 0 in every state.
//  - FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010.
//    irwrite and pcwrite (pcsrc=00) are asserted only in the cycle with mem_ready=1; that cycle -> DECODE.
//    Otherwise stay in FETCH.
//  - DECODE: alusrcb=11, alucontrol=010 (precompute branch target). Next state by opcode:
//    100011/101011 -> MEMADR; 000000 -> JR if funct=001000, EXEC if funct in {100000,100010,100100,100101,101010},
//    else ERROR(01); 000100/000001 -> BRANCH; 001000/001101/001111 -> IEXEC; 000010/000011 -> JUMP;
//    any other opcode -> ERROR(01).
//  - MEMADR: alusrca=1, alusrcb=10, immsel=00, add. lw -> MEMRD, sw -> MEMWR.
//  - MEMRD: memread=1, iord=1; on mem_ready -> MEMWB.
//  - MEMWR: memwrite=1, iord=1; on mem_ready -> FETCH.
//  - MEMWB: regwrite=1, regdst=00, memtoreg=01 -> FETCH.
//  - EXEC: alusrca=1, alusrcb=00, alucontrol from funct (add 010, sub 110, and 000, or 001, slt 111) -> ALUWB.
//  - ALUWB: regwrite=1, regdst=01, memtoreg=00 -> FETCH.
//  - IEXEC: alusrca=1, alusrcb=10. addi: immsel 00, add. ori: immsel 01, or. lui: immsel 10, or with rs=$0. -> IWB.
//  - IWB: regwrite=1, regdst=00, memtoreg=00 -> FETCH.
//  - BRANCH: alusrca=1, alusrcb=00, pcsrc=01.
//    beq: alucontrol=110, pcwrite=zero. bltz: alucontrol=111 (rs<$0), pcwrite=~zero. -> FETCH.
//  - JUMP: pcwrite=1, pcsrc=10. jal also asserts regwrite=1, regdst=10, memtoreg=10. -> FETCH.
//  - JR: pcwrite=1, pcsrc=11 -> FETCH.
//  - Latency with mem_ready tied 1: lw 5; R-type, I-type, sw 4; beq/bltz/j/jal/jr 3 cycles.
//    Each mem_ready=0 cycle adds one cycle.
//  - Wait counter: increments each cycle in FETCH/MEMRD/MEMWR with mem_ready=0.
//    Cleared on mem_ready=1 and on any state change.
//    If counter==MEM_WAIT_MAX with mem_ready still 0 -> ERROR(10). mem_ready=1 on that same cycle wins (no error).
//  - ERROR: all strobes 0, err=1. Left only by reset. Reset mid-access aborts it immediately; no strobe glitch.
// TESTING
//  - mem_ready=1, add (000000/100000): states 1,2,7,8,1.
//    regwrite=1 only in ALUWB with regdst=01; pcwrite only in FETCH.
//  - lw, mem_ready low 3 cycles in MEMRD: MEMRD held 4 cycles, then MEMWB regwrite=1 memtoreg=01; total 8 cycles.
//  - beq zero=1 -> pcwrite=1 pcsrc=01; bltz zero=1 -> pcwrite=0; jal -> regwrite=1 regdst=10 memtoreg=10.
//  - opcode 111111 in DECODE -> state 15, err=1, err_cause=01.
//    Stays in ERROR for 20 cycles; reset low -> IDLE, then FETCH.
//  - MEM_WAIT_MAX=15, mem_ready=0 in FETCH: ERROR(10) exactly 16 cycles after FETCH entry.
//    mem_ready=1 on cycle 16 instead -> DECODE, err=0.
//  - reset asserted mid-MEMWR with memwrite=1: memwrite drops asynchronously, state=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for a multi-cycle MIPS datapath sharing one memory port between fetch and data access.
// Memory states stall on mem_ready and trap to a sticky ERROR state on timeout or an illegal instruction.
module multicycle_controller #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic [1:0] pcsrc,
  output logic       regwrite,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsel,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       err,
  output logic [1:0] err_cause
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StIExec  = 4'd10,
    StIWb    = 4'd11,
    StJump   = 4'd12,
    StJr     = 4'd13,
    StError  = 4'd15
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBltz  = 6'b000001;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnJr  = 6'b001000;
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseIllegal = 2'b01;
  localparam logic [1:0] CauseTimeout = 2'b10;

  localparam logic [7:0] WaitMax = 8'(MEM_WAIT_MAX);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] cause_q, cause_d;
  logic       mem_state;
  logic       timeout;
  logic       rtype_alu;

  assign mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign timeout   = mem_state && !mem_ready && (wait_q == WaitMax);
  assign rtype_alu = (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) ||
                     (funct == FnOr)  || (funct == FnSlt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      wait_q  <= '0;
      cause_q <= CauseNone;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        unique case (opcode)
          OpLw, OpSw:          state_d = StMemAdr;
          OpBeq, OpBltz:       state_d = StBranch;
          OpAddi, OpOri, OpLui: state_d = StIExec;
          OpJ, OpJal:          state_d = StJump;
          OpRtype: begin
            if (funct == FnJr) begin
              state_d = StJr;
            end else if (rtype_alu) begin
              state_d = StExec;
            end else begin
              state_d = StError;
              cause_d = CauseIllegal;
            end
          end
          default: begin
            state_d = StError;
            cause_d = CauseIllegal;
          end
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StExec:   state_d = StAluWb;
      StIExec:  state_d = StIWb;
      StMemWb, StAluWb, StIWb, StBranch, StJump, StJr: state_d = StFetch;
      default:  state_d = StError;
    endcase
    // A ready on the final allowed wait cycle wins over the timeout.
    if (timeout) begin
      state_d = StError;
      cause_d = CauseTimeout;
    end
  end

  always_comb begin
    if (!mem_state || mem_ready || (state_d != state_q)) begin
      wait_d = '0;
    end else begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_comb begin
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    pcsrc      = 2'b00;
    regwrite   = 1'b0;
    regdst     = 2'b00;
    memtoreg   = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    immsel     = 2'b00;
    alucontrol = AluAnd;
    unique case (state_q)
      StFetch: begin
        memread    = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = AluAdd;
        irwrite    = mem_ready;
        pcwrite    = mem_ready;
      end
      StDecode: begin
        alusrcb    = 2'b11;
        alucontrol = AluAdd;
      end
      StMemAdr: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = AluAdd;
      end
      StMemRd: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      StMemWr: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      StMemWb: begin
        regwrite = 1'b1;
        memtoreg = 2'b01;
      end
      StExec: begin
        alusrca = 1'b1;
        unique case (funct)
          FnSub:   alucontrol = AluSub;
          FnAnd:   alucontrol = AluAnd;
          FnOr:    alucontrol = AluOr;
          FnSlt:   alucontrol = AluSlt;
          default: alucontrol = AluAdd;
        endcase
      end
      StAluWb: begin
        regwrite = 1'b1;
        regdst   = 2'b01;
      end
      StBranch: begin
        alusrca = 1'b1;
        pcsrc   = 2'b01;
        if (opcode == OpBeq) begin
          alucontrol = AluSub;
          pcwrite    = zero;
        end else begin
          // bltz: slt against $0 leaves zero clear when rs is negative.
          alucontrol = AluSlt;
          pcwrite    = ~zero;
        end
      end
      StIExec: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        unique case (opcode)
          OpOri: begin
            immsel     = 2'b01;
            alucontrol = AluOr;
          end
          OpLui: begin
            // rs field of lui is $0, so or passes the shifted immediate.
            immsel     = 2'b10;
            alucontrol = AluOr;
          end
          default: alucontrol = AluAdd;
        endcase
      end
      StIWb: regwrite = 1'b1;
      StJump: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        if (opcode == OpJal) begin
          regwrite = 1'b1;
          regdst   = 2'b10;
          memtoreg = 2'b10;
        end
      end
      StJr: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b11;
      end
      default: ;
    endcase
  end

  assign state     = state_q;
  assign err       = (state_q == StError);
  assign err_cause = cause_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised instruction stream with random memory wait states, checked every cycle against an
// instruction-level model that plans the expected phase sequence and per-phase strobes.
module tb_multicycle_controller;

  localparam int MAX = 15;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsel;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       err;
    logic [1:0] err_cause;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       memread, memwrite, iord, irwrite, pcwrite, regwrite, alusrca, err;
  logic [1:0] pcsrc, regdst, memtoreg, alusrcb, immsel, err_cause;
  logic [2:0] alucontrol;
  logic [3:0] state;

  ctl_t act, exp_c, last;
  logic exp_valid = 1'b0;
  logic [1:0] cause_m = 2'b00;
  ctl_t trace[$];
  int asserts = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_WAIT_MAX(MAX)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .memread(memread), .memwrite(memwrite), .iord(iord),
    .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .immsel(immsel), .alucontrol(alucontrol), .state(state), .err(err),
    .err_cause(err_cause)
  );

  assign act = {memread, memwrite, iord, irwrite, pcwrite, pcsrc, regwrite, regdst, memtoreg,
                alusrca, alusrcb, immsel, alucontrol, state, err, err_cause};

  // Expected strobes for one phase of an instruction, straight from the control table.
  function automatic ctl_t model(input int ph, input logic [5:0] op, input logic [5:0] fn,
                                 input logic zr, input logic rdy, input logic [1:0] cause);
    ctl_t c;
    c = '0;
    c.state = 4'(ph);
    case (ph)
      1: begin
        c.memread = 1; c.alusrcb = 2'b01; c.alucontrol = 3'b010;
        c.irwrite = rdy; c.pcwrite = rdy;
      end
      2: begin c.alusrcb = 2'b11; c.alucontrol = 3'b010; end
      3: begin c.alusrca = 1; c.alusrcb = 2'b10; c.alucontrol = 3'b010; end
      4: begin c.memread = 1; c.iord = 1; end
      5: begin c.regwrite = 1; c.memtoreg = 2'b01; end
      6: begin c.memwrite = 1; c.iord = 1; end
      7: begin
        c.alusrca = 1;
        case (fn)
          6'b100000: c.alucontrol = 3'b010;
          6'b100010: c.alucontrol = 3'b110;
          6'b100100: c.alucontrol = 3'b000;
          6'b100101: c.alucontrol = 3'b001;
          default:   c.alucontrol = 3'b111;
        endcase
      end
      8: begin c.regwrite = 1; c.regdst = 2'b01; end
      9: begin
        c.alusrca = 1; c.pcsrc = 2'b01;
        c.alucontrol = (op == 6'b000100) ? 3'b110 : 3'b111;
        c.pcwrite = (op == 6'b000100) ? zr : ~zr;
      end
      10: begin
        c.alusrca = 1; c.alusrcb = 2'b10;
        if (op == 6'b001101) begin c.immsel = 2'b01; c.alucontrol = 3'b001; end
        else if (op == 6'b001111) begin c.immsel = 2'b10; c.alucontrol = 3'b001; end
        else c.alucontrol = 3'b010;
      end
      11: c.regwrite = 1;
      12: begin
        c.pcwrite = 1; c.pcsrc = 2'b10;
        if (op == 6'b000011) begin c.regwrite = 1; c.regdst = 2'b10; c.memtoreg = 2'b10; end
      end
      13: begin c.pcwrite = 1; c.pcsrc = 2'b11; end
      15: begin c.err = 1; c.err_cause = cause; end
      default: ;
    endcase
    return c;
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      asserts++;
      if (act !== exp_c) begin
        failures++;
        $display("FAIL cycle_model phase=%0d: got %h expected %h", exp_c.state, act, exp_c);
      end
    end
  end

  task automatic chk(input string nm, input int a, input int e);
    asserts++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic step(input int ph, input logic rdy);
    mem_ready = rdy;
    exp_c = model(ph, opcode, funct, zero, rdy, cause_m);
    exp_valid = 1'b1;
    @(negedge clk);
    last = act;
    trace.push_back(act);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", int'(act), 0);
    cause_m = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, 1'($urandom_range(0, 1)));
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55) return 0;
    if (r < 85) return $urandom_range(1, 3);
    if (r < 91) return MAX;
    if (r < 97) return $urandom_range(4, MAX - 1);
    return MAX + 1;
  endfunction

  // Runs one instruction from FETCH; fw/mw < 0 pick random wait counts for fetch/data access.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zr,
                           input int fw, input int mw, input int errc);
    int  ph[$];
    bit  bad, illegal;
    int  w;
    logic rdy;
    trace.delete();
    opcode = op; funct = fn; zero = zr;
    illegal = 0;
    bad = 0;
    ph.push_back(1);
    ph.push_back(2);
    case (op)
      6'b100011: begin ph.push_back(3); ph.push_back(4); ph.push_back(5); end
      6'b101011: begin ph.push_back(3); ph.push_back(6); end
      6'b000000: begin
        if (fn == 6'b001000) ph.push_back(13);
        else if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
          ph.push_back(7); ph.push_back(8);
        end else illegal = 1;
      end
      6'b000100, 6'b000001: ph.push_back(9);
      6'b001000, 6'b001101, 6'b001111: begin ph.push_back(10); ph.push_back(11); end
      6'b000010, 6'b000011: ph.push_back(12);
      default: illegal = 1;
    endcase
    foreach (ph[i]) begin
      if (ph[i] == 1 || ph[i] == 4 || ph[i] == 6) begin
        w = (ph[i] == 1) ? fw : mw;
        if (w < 0) w = pick_wait();
        for (int k = 0; k <= MAX; k++) begin
          rdy = (k >= w);
          step(ph[i], rdy);
          if (rdy) break;
          if (k == MAX) begin
            bad = 1;
            cause_m = 2'b10;
          end
        end
      end else begin
        step(ph[i], 1'($urandom_range(0, 1)));
      end
      if (bad) break;
    end
    if (!bad && illegal) begin
      bad = 1;
      cause_m = 2'b01;
    end
    if (bad) begin
      repeat (errc) step(15, 1'($urandom_range(0, 1)));
      do_reset();
    end
  endtask

  function automatic int count_state(input int s);
    int n;
    n = 0;
    foreach (trace[i]) if (int'(trace[i].state) == s) n++;
    return n;
  endfunction

  logic [5:0] lop[15] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                          6'b000000, 6'b000000, 6'b000100, 6'b000001, 6'b001000, 6'b001101,
                          6'b001111, 6'b000010, 6'b000011};
  logic [5:0] lfn[15] = '{6'b0, 6'b0, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                          6'b001000, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};

  initial begin
    logic [5:0] op, fn;
    int r, idx;
    @(posedge clk);
    #1;
    do_reset();

    // add with memory always ready: 1,2,7,8 then back to FETCH
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1);
    chk("add_len", trace.size(), 4);
    chk("add_s0", int'(trace[0].state), 1);
    chk("add_s2", int'(trace[2].state), 7);
    chk("add_s3", int'(trace[3].state), 8);
    chk("add_wb_regdst", int'({trace[3].regwrite, trace[3].regdst}), 3'b101);
    chk("add_fetch_pcwrite", int'(trace[0].pcwrite), 1);
    chk("add_regwrite_cnt", int'(trace[0].regwrite) + int'(trace[1].regwrite)
        + int'(trace[2].regwrite), 0);

    // lw with three wait cycles in MEMRD
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 3, 1);
    chk("lw_total_cycles", trace.size(), 8);
    chk("lw_memrd_cycles", count_state(4), 4);
    chk("lw_wb", int'({trace[7].state, trace[7].regwrite, trace[7].memtoreg}), 'b0101_1_01);

    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, 1);
    chk("beq_taken", int'({last.pcwrite, last.pcsrc}), 3'b101);
    run_instr(6'b000001, 6'b000000, 1'b1, 0, 0, 1);
    chk("bltz_zero_not_taken", int'(last.pcwrite), 0);
    run_instr(6'b000011, 6'b000000, 1'b0, 0, 0, 1);
    chk("jal_link", int'({last.regwrite, last.regdst, last.memtoreg}), 5'b1_10_10);

    // illegal opcode: 20 cycles in ERROR, then reset
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, 20);
    chk("illegal_state", int'(trace[2].state), 15);
    chk("illegal_cause", int'({trace[21].err, trace[21].err_cause}), 3'b101);
    chk("illegal_after_reset", int'(last.state), 0);

    // fetch timeout at the 16th wait cycle, and ready on that cycle rescues it
    run_instr(6'b000000, 6'b001000, 1'b0, MAX + 1, 0, 2);
    chk("timeout_fetch_cycles", count_state(1), MAX + 1);
    chk("timeout_cause", int'({trace[MAX + 1].state, trace[MAX + 1].err_cause}), 'b1111_10);
    run_instr(6'b000000, 6'b001000, 1'b0, MAX, 0, 1);
    chk("rescue_decode", int'({trace[MAX + 1].state, trace[MAX + 1].err}), 'b0010_0);

    // reset in the middle of a store access
    opcode = 6'b101011; funct = 6'b0; zero = 1'b0;
    trace.delete();
    step(1, 1'b1);
    step(2, 1'b0);
    step(3, 1'b0);
    step(6, 1'b0);
    step(6, 1'b0);
    #2;
    chk("memwr_active", int'(memwrite), 1);
    do_reset();

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin op = 6'b111111; fn = 6'($urandom); end
      else if (r == 3) begin op = 6'b000000; fn = 6'b000001; end
      else if (r == 4) begin op = 6'b010000; fn = 6'($urandom); end
      else begin
        idx = $urandom_range(0, 14);
        op = lop[idx];
        fn = (op == 6'b000000) ? lfn[idx] : 6'($urandom);
      end
      run_instr(op, fn, 1'($urandom_range(0, 1)), -1, -1, $urandom_range(1, 4));
    end

    exp_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
